// File: rtl/cache_return_receiver.sv
// Cache return receiver: in-order return FIFO toward writeback,
// plus request credits so outstanding requests always fit the FIFO.
module cache_return_receiver #(
  parameter int XLEN         = 64,
  parameter int CACHE_USER_W = 8,
  parameter int ID_W         = 8,
  parameter int DEPTH        = 4
) (
  input  logic                      clk_i,
  input  logic                      arst_n_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      ret_valid_i,
  input  logic [2*XLEN-1:0]         ret_rdata_i,
  input  logic [ID_W-1:0]           ret_id_i,
  input  logic [CACHE_USER_W-1:0]   ret_user_i,
  input  logic [5:0]                ret_error_i,
  input  logic                      ret_mmio_i,
  output logic                      wb_valid_o,
  input  logic                      wb_ready_i,
  output logic [2*XLEN-1:0]         wb_rdata_o,
  output logic [ID_W-1:0]           wb_id_o,
  output logic [CACHE_USER_W-1:0]   wb_user_o,
  output logic [5:0]                wb_error_o,
  output logic                      wb_mmio_o,
  output logic                      wb_fault_o,
  output logic [$clog2(DEPTH):0]    occupancy_o,
  output logic [$clog2(DEPTH):0]    in_flight_o,
  output logic                      overflow_o,
  output logic                      spurious_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] ONE = PW'(1);
  localparam logic [PW-1:0] CAP = PW'(DEPTH);

  typedef struct packed {
    logic [2*XLEN-1:0]       rdata;
    logic [ID_W-1:0]         id;
    logic [CACHE_USER_W-1:0] user;
    logic [5:0]              error;
    logic                    mmio;
  } beat_t;

  beat_t         mem [DEPTH];
  beat_t         head;
  beat_t         wbeat;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] in_flight;
  logic [PW-1:0] occ;
  logic          empty;
  logic          full;
  logic          deq;
  logic          enq;
  logic          fire;

  assign occ   = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0])
              && (wr_ptr[AW] != rd_ptr[AW]);

  assign wb_valid_o  = !empty;
  assign deq         = wb_valid_o && wb_ready_i;
  assign enq         = ret_valid_i && (!full || deq);
  assign req_ready_o = (in_flight < CAP);
  assign fire        = req_valid_i && req_ready_o;

  assign wbeat = '{
    rdata: ret_rdata_i,
    id:    ret_id_i,
    user:  ret_user_i,
    error: ret_error_i,
    mmio:  ret_mmio_i
  };

  // Storage is cleared on reset so the payload outputs read zero.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (enq) begin
      mem[wr_ptr[AW-1:0]] <= wbeat;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_o <= 1'b0;
      spurious_o <= 1'b0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + ONE;
      end
      if (deq) begin
        rd_ptr <= rd_ptr + ONE;
      end
      if (ret_valid_i && full && !deq) begin
        overflow_o <= 1'b1;
      end
      if (ret_valid_i && (in_flight == occ)) begin
        spurious_o <= 1'b1;
      end
    end
  end

  // Floor at zero guards against dequeues of spurious beats.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      in_flight <= '0;
    end else begin
      unique case (1'b1)
        (fire && !deq): in_flight <= in_flight + ONE;
        (deq && !fire && in_flight != '0):
          in_flight <= in_flight - ONE;
        default: in_flight <= in_flight;
      endcase
    end
  end

  assign head        = mem[rd_ptr[AW-1:0]];
  assign wb_rdata_o  = head.rdata;
  assign wb_id_o     = head.id;
  assign wb_user_o   = head.user;
  assign wb_error_o  = head.error;
  assign wb_mmio_o   = head.mmio;
  assign wb_fault_o  = wb_valid_o && (head.error != 6'd0);
  assign occupancy_o = occ;
  assign in_flight_o = in_flight;

endmodule

// File: tb/tb_cache_return_receiver.sv
// Bench for cache_return_receiver: directed scenarios plus random
// legal traffic, checked against a queue-based reference model.
module tb_cache_return_receiver;

  localparam int D = 4;

  typedef struct {
    logic [127:0] rdata;
    logic [7:0]   id;
    logic [7:0]   user;
    logic [5:0]   error;
    logic         mmio;
  } mbeat_t;

  logic         clk;
  logic         arst_n;
  logic         req_valid;
  logic         req_ready;
  logic         ret_valid;
  logic [127:0] ret_rdata;
  logic [7:0]   ret_id;
  logic [7:0]   ret_user;
  logic [5:0]   ret_error;
  logic         ret_mmio;
  logic         wb_valid;
  logic         wb_ready;
  logic [127:0] wb_rdata;
  logic [7:0]   wb_id;
  logic [7:0]   wb_user;
  logic [5:0]   wb_error;
  logic         wb_mmio;
  logic         wb_fault;
  logic [2:0]   occupancy;
  logic [2:0]   in_flight;
  logic         overflow;
  logic         spurious;

  int     n_assert = 0;
  int     n_fail   = 0;
  mbeat_t mq[$];
  int     m_infl   = 0;
  bit     m_ovf    = 0;
  bit     m_spur   = 0;

  cache_return_receiver #(
    .XLEN(64), .CACHE_USER_W(8), .ID_W(8), .DEPTH(D)
  ) dut (
    .clk_i       (clk),
    .arst_n_i    (arst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .ret_valid_i (ret_valid),
    .ret_rdata_i (ret_rdata),
    .ret_id_i    (ret_id),
    .ret_user_i  (ret_user),
    .ret_error_i (ret_error),
    .ret_mmio_i  (ret_mmio),
    .wb_valid_o  (wb_valid),
    .wb_ready_i  (wb_ready),
    .wb_rdata_o  (wb_rdata),
    .wb_id_o     (wb_id),
    .wb_user_o   (wb_user),
    .wb_error_o  (wb_error),
    .wb_mmio_o   (wb_mmio),
    .wb_fault_o  (wb_fault),
    .occupancy_o (occupancy),
    .in_flight_o (in_flight),
    .overflow_o  (overflow),
    .spurious_o  (spurious)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [127:0] obs,
                     logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic check_model();
    bit fexp;
    chk("wb_valid", wb_valid, mq.size() != 0);
    chk("occupancy", occupancy, mq.size());
    chk("in_flight", in_flight, m_infl);
    chk("req_ready", req_ready, m_infl < D);
    chk("overflow", overflow, m_ovf);
    chk("spurious", spurious, m_spur);
    fexp = (mq.size() != 0) && (mq[0].error != 0);
    chk("wb_fault", wb_fault, fexp);
    if (mq.size() != 0) begin
      chk("wb_rdata", wb_rdata, mq[0].rdata);
      chk("wb_id", wb_id, mq[0].id);
      chk("wb_user", wb_user, mq[0].user);
      chk("wb_error", wb_error, mq[0].error);
      chk("wb_mmio", wb_mmio, mq[0].mmio);
    end
  endtask

  // Predict the effect of the coming edge, then check after it.
  task automatic step();
    bit     deq;
    bit     fire;
    bit     full;
    mbeat_t b;
    deq  = (mq.size() != 0) && wb_ready;
    fire = req_valid && (m_infl < D);
    full = (mq.size() == D);
    b = '{ret_rdata, ret_id, ret_user, ret_error, ret_mmio};
    if (ret_valid && m_infl == mq.size()) m_spur = 1;
    if (deq) void'(mq.pop_front());
    if (ret_valid) begin
      if (!full || deq) mq.push_back(b);
      else m_ovf = 1;
    end
    if (fire && !deq) m_infl++;
    else if (deq && !fire && m_infl > 0) m_infl--;
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic set_ret(bit v, logic [127:0] d,
                         logic [7:0] id, logic [7:0] u,
                         logic [5:0] e, bit m);
    ret_valid = v;
    ret_rdata = d;
    ret_id    = id;
    ret_user  = u;
    ret_error = e;
    ret_mmio  = m;
  endtask

  task automatic idle();
    req_valid = 0;
    wb_ready  = 0;
    set_ret(0, '0, '0, '0, '0, 0);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_reset();
    arst_n = 0;
    #1;
    mq.delete();
    m_infl = 0;
    m_ovf  = 0;
    m_spur = 0;
    check_model();
    chk("rst_rdata", wb_rdata, 0);
    chk("rst_id", wb_id, 0);
    chk("rst_user", wb_user, 0);
    chk("rst_error", wb_error, 0);
    chk("rst_mmio", wb_mmio, 0);
    idle();
    #3;
    arst_n = 1;
    step();
  endtask

  initial begin
    idle();
    arst_n = 1;
    #2;
    do_reset();

    // basic path
    req_valid = 1;
    step();
    req_valid = 0;
    set_ret(1, 128'h1234, 8'd3, 8'd0, 6'd0, 0);
    #1;
    chk("no_bypass", wb_valid, 0);
    step();
    set_ret(0, '0, '0, '0, '0, 0);
    chk("basic_valid", wb_valid, 1);
    chk("basic_id", wb_id, 3);
    chk("basic_data", wb_rdata, 128'h1234);
    wb_ready = 1;
    step();
    wb_ready = 0;
    chk("basic_drained", wb_valid, 0);
    chk("basic_infl", in_flight, 0);

    // credit limit
    req_valid = 1;
    repeat (6) step();
    req_valid = 0;
    chk("credit_ready", req_ready, 0);
    chk("credit_infl", in_flight, 4);
    set_ret(1, rnd128(), 8'h20, 8'h1, 6'd0, 0);
    step();
    set_ret(0, '0, '0, '0, '0, 0);
    chk("credit_still_0", req_ready, 0);
    wb_ready = 1;
    step();
    wb_ready = 0;
    chk("credit_restored", req_ready, 1);
    do_reset();

    // full with concurrent dequeue
    req_valid = 1;
    repeat (4) step();
    req_valid = 0;
    for (int i = 0; i < 4; i++) begin
      set_ret(1, rnd128(), 8'(i), 8'(i), 6'd0, 0);
      step();
    end
    chk("full_occ", occupancy, 4);
    set_ret(1, rnd128(), 8'd4, 8'd4, 6'd0, 0);
    wb_ready = 1;
    step();
    set_ret(0, '0, '0, '0, '0, 0);
    chk("full_conc_occ", occupancy, 4);
    chk("full_conc_ovf", overflow, 0);
    for (int k = 1; k <= 4; k++) begin
      chk("drain_order", wb_id, k);
      step();
    end
    wb_ready = 0;
    do_reset();

    // overflow
    req_valid = 1;
    repeat (4) step();
    req_valid = 0;
    for (int i = 0; i < 5; i++) begin
      set_ret(1, rnd128(), 8'(10 + i), 8'h0, 6'd0, 0);
      step();
    end
    set_ret(0, '0, '0, '0, '0, 0);
    chk("ovf_set", overflow, 1);
    chk("ovf_head", wb_id, 10);
    chk("ovf_occ", occupancy, 4);
    wb_ready = 1;
    repeat (4) step();
    wb_ready = 0;
    chk("ovf_sticky", overflow, 1);
    do_reset();
    chk("ovf_cleared", overflow, 0);

    // error / mmio pass-through
    req_valid = 1;
    step();
    req_valid = 0;
    set_ret(1, rnd128(), 8'd7, 8'hA5, 6'h05, 1);
    step();
    set_ret(0, '0, '0, '0, '0, 0);
    chk("err_fault", wb_fault, 1);
    chk("err_code", wb_error, 6'h05);
    chk("err_mmio", wb_mmio, 1);
    chk("err_user", wb_user, 8'hA5);
    wb_ready = 1;
    step();
    wb_ready = 0;
    chk("err_fault_gone", wb_fault, 0);
    do_reset();

    // spurious then async reset mid-stream
    set_ret(1, rnd128(), 8'h33, 8'h3, 6'd0, 0);
    step();
    set_ret(0, '0, '0, '0, '0, 0);
    chk("spur_set", spurious, 1);
    req_valid = 1;
    for (int i = 0; i < 3; i++) begin
      set_ret(1, rnd128(), 8'(40 + i), 8'h7, 6'h1, 1);
      step();
    end
    chk("pre_rst_valid", wb_valid, 1);
    #2;
    do_reset();
    chk("post_rst_spur", spurious, 0);

    // random legal traffic
    for (int c = 0; c < 400; c++) begin
      req_valid = 1'($urandom % 2);
      wb_ready  = ($urandom % 3) != 0;
      if (m_infl > mq.size() && ($urandom % 2) == 1)
        set_ret(1, rnd128(), 8'($urandom), 8'($urandom),
                (($urandom % 4) == 0) ? 6'($urandom) : 6'd0,
                1'($urandom % 2));
      else
        set_ret(0, '0, '0, '0, '0, 0);
      step();
    end
    chk("rand_no_ovf", overflow, 0);
    chk("rand_no_spur", spurious, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
